// File: rtl/clock_time_ctrl_if.sv
// rtl/clock_time_ctrl_if.sv - tick/button inputs and time/mode outputs of the clock time controller
interface clock_time_ctrl_if;
  logic       en_1clk;
  logic       debclk_10hz;
  logic       btn_mode;
  logic       btn_up;
  logic [4:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic [1:0] mode;
  logic       blink;
  logic       day_pulse;

  modport master (
    output en_1clk, debclk_10hz, btn_mode, btn_up,
    input  hour, min, sec, mode, blink, day_pulse
  );

  modport slave (
    input  en_1clk, debclk_10hz, btn_mode, btn_up,
    output hour, min, sec, mode, blink, day_pulse
  );
endinterface

// File: rtl/clock_time_ctrl.sv
// rtl/clock_time_ctrl.sv - debounced mode/set FSM and hh:mm:ss time keeping for the digital clock
module clock_time_ctrl #(
  parameter int HOLD_SAMPLES   = 5,
  parameter bit BTN_ACTIVE_LOW = 1'b1
) (
  input logic             clk,
  input logic             rst,
  clock_time_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } state_t;

  localparam int HW = $clog2(HOLD_SAMPLES + 1);

  state_t        r_state;
  state_t        w_next_state;
  logic [2:0]    r_deb_sync;
  logic          r_samp_stb;
  logic [1:0]    r_mode_sync;
  logic [1:0]    r_up_sync;
  logic          r_mode_samp;
  logic          r_up_samp;
  logic [HW-1:0] r_hold;
  logic [4:0]    r_hour;
  logic [5:0]    r_min;
  logic [5:0]    r_sec;
  logic          r_blink;
  logic          r_day_pulse;

  logic          w_mode_raw;
  logic          w_up_raw;
  logic          w_mode_act;
  logic          w_up_act;
  logic          w_mode_press;
  logic          w_up_press;
  logic          w_up_rep;
  logic          w_up_evt;
  logic          w_sec_wrap;
  logic          w_min_wrap;
  logic          w_hour_wrap;

  // Buttons are turned active-high before synchronizing, so cleared flops mean "released".
  assign w_mode_raw = bus.btn_mode ^ BTN_ACTIVE_LOW;
  assign w_up_raw   = bus.btn_up ^ BTN_ACTIVE_LOW;
  assign w_mode_act = r_mode_sync[1];
  assign w_up_act   = r_up_sync[1];

  // Press = active sample after an inactive one; repeat once the hold count has saturated.
  assign w_mode_press = r_samp_stb & w_mode_act & ~r_mode_samp;
  assign w_up_press   = r_samp_stb & w_up_act & ~r_up_samp;
  assign w_up_rep     = r_samp_stb & w_up_act & (r_hold == HW'(HOLD_SAMPLES));
  assign w_up_evt     = (w_up_press | w_up_rep) & ~w_mode_press;

  assign w_sec_wrap  = (r_sec == 6'd59);
  assign w_min_wrap  = (r_min == 6'd59);
  assign w_hour_wrap = (r_hour == 5'd23);

  // Synchronize the 10 Hz debounce clock and both buttons; strobe once per debounce rising edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_deb_sync  <= '0;
      r_samp_stb  <= 1'b0;
      r_mode_sync <= '0;
      r_up_sync   <= '0;
    end else begin
      r_deb_sync  <= {r_deb_sync[1:0], bus.debclk_10hz};
      r_samp_stb  <= r_deb_sync[1] & ~r_deb_sync[2];
      r_mode_sync <= {r_mode_sync[0], w_mode_raw};
      r_up_sync   <= {r_up_sync[0], w_up_raw};
    end
  end

  // Capture debounce samples and run the UP hold counter on each strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mode_samp <= 1'b0;
      r_up_samp   <= 1'b0;
      r_hold      <= '0;
    end else if (r_samp_stb) begin
      r_mode_samp <= w_mode_act;
      r_up_samp   <= w_up_act;
      if (!w_up_act) begin
        r_hold <= '0;
      end else if (r_hold < HW'(HOLD_SAMPLES)) begin
        r_hold <= r_hold + HW'(1);
      end
    end
  end

  // Mode state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Mode sequencing on MODE presses; an illegal state falls back to RUN.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      RUN:     if (w_mode_press) w_next_state = SET_HR;
      SET_HR:  if (w_mode_press) w_next_state = SET_MIN;
      SET_MIN: if (w_mode_press) w_next_state = RUN;
      default: w_next_state = RUN;
    endcase
  end

  // Time counters: ticks with carry in RUN, carry-free field increments in the set modes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hour      <= '0;
      r_min       <= '0;
      r_sec       <= '0;
      r_day_pulse <= 1'b0;
    end else begin
      r_day_pulse <= 1'b0;
      case (r_state)
        RUN: begin
          if (bus.en_1clk) begin
            r_sec <= (r_sec >= 6'd59) ? 6'd0 : r_sec + 6'd1;
            if (w_sec_wrap) begin
              r_min <= (r_min >= 6'd59) ? 6'd0 : r_min + 6'd1;
              if (w_min_wrap) begin
                r_hour      <= (r_hour >= 5'd23) ? 5'd0 : r_hour + 5'd1;
                r_day_pulse <= w_hour_wrap;
              end
            end
          end
        end
        SET_HR: begin
          if (w_up_evt) begin
            r_hour <= (r_hour >= 5'd23) ? 5'd0 : r_hour + 5'd1;
          end
        end
        SET_MIN: begin
          if (w_mode_press) begin
            r_sec <= 6'd0;
          end else if (w_up_evt) begin
            r_min <= (r_min >= 6'd59) ? 6'd0 : r_min + 6'd1;
          end
        end
        default: begin
          r_sec <= r_sec;
        end
      endcase
    end
  end

  // Blink gate: solid in RUN, starts dark on entering SET_HR, toggles per strobe while setting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_blink <= 1'b1;
    end else if (w_next_state == RUN) begin
      r_blink <= 1'b1;
    end else if (r_state == RUN) begin
      r_blink <= 1'b0;
    end else if (r_samp_stb) begin
      r_blink <= ~r_blink;
    end
  end

  assign bus.hour      = r_hour;
  assign bus.min       = r_min;
  assign bus.sec       = r_sec;
  assign bus.mode      = r_state;
  assign bus.blink     = r_blink;
  assign bus.day_pulse = r_day_pulse;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// tb/tb_clock_time_ctrl.sv - randomized self-checking bench for clock_time_ctrl against a time/mode model
module tb_clock_time_ctrl;
  localparam int HOLD    = 5;
  localparam bit ACT_LOW = 1'b1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  clock_time_ctrl_if u_if ();

  clock_time_ctrl #(
    .HOLD_SAMPLES  (HOLD),
    .BTN_ACTIVE_LOW(ACT_LOW)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(u_if.slave)
  );

  always #5 clk = ~clk;

  int n_cmp   = 0;
  int n_err   = 0;
  int day_cnt = 0;

  int m_hour, m_min, m_sec, m_mode, m_blink, m_days, m_hold;
  bit m_mprev, m_uprev;
  bit up_lvl;
  int r;

  // Counts every clock cycle in which day_pulse is high.
  always @(negedge clk) if (u_if.day_pulse === 1'b1) day_cnt++;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string where);
    check({where, " hour"}, int'(u_if.hour), m_hour);
    check({where, " min"}, int'(u_if.min), m_min);
    check({where, " sec"}, int'(u_if.sec), m_sec);
    check({where, " mode"}, int'(u_if.mode), m_mode);
    check({where, " blink"}, int'(u_if.blink), m_blink);
    check({where, " days"}, day_cnt, m_days);
  endtask

  task automatic m_reset();
    m_hour = 0; m_min = 0; m_sec = 0; m_mode = 0; m_blink = 1;
    m_hold = 0; m_mprev = 0; m_uprev = 0;
  endtask

  // One second of wall time in RUN, done as seconds-of-day arithmetic.
  task automatic m_tick();
    int t;
    if (m_mode == 0) begin
      t = m_hour * 3600 + m_min * 60 + m_sec + 1;
      if (t == 86400) begin
        t = 0;
        m_days++;
      end
      m_hour = t / 3600;
      m_min  = (t / 60) % 60;
      m_sec  = t % 60;
    end
  endtask

  // One debounce sample of the (active-high) button levels.
  task automatic m_sample(input bit mp, input bit up);
    bit mpress, uevt;
    mpress = mp && !m_mprev;
    uevt   = up && (!m_uprev || m_hold == HOLD);
    m_hold = up ? ((m_hold < HOLD) ? m_hold + 1 : HOLD) : 0;
    m_mprev = mp;
    m_uprev = up;
    if (mpress) begin
      m_mode = (m_mode + 1) % 3;
      if (m_mode == 0) m_sec = 0;
    end else if (uevt) begin
      if (m_mode == 1) m_hour = (m_hour + 1) % 24;
      else if (m_mode == 2) m_min = (m_min + 1) % 60;
    end
    if (m_mode == 0) m_blink = 1;
    else if (mpress && m_mode == 1) m_blink = 0;
    else m_blink = !m_blink;
  endtask

  task automatic drive_btn(input bit mp, input bit up);
    u_if.btn_mode = ACT_LOW ? ~mp : mp;
    u_if.btn_up   = ACT_LOW ? ~up : up;
  endtask

  task automatic tick();
    @(negedge clk); u_if.en_1clk = 1'b1;
    @(negedge clk); u_if.en_1clk = 1'b0;
    @(posedge clk); #1;
    m_tick();
    check_all("tick");
  endtask

  // Settle buttons, raise the debounce clock; optionally put en_1clk on the action edge.
  task automatic sample(input bit mp, input bit up, input bit do_tick);
    @(negedge clk); drive_btn(mp, up);
    repeat (4) @(negedge clk);
    u_if.debclk_10hz = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); if (do_tick) u_if.en_1clk = 1'b1;
    @(negedge clk); u_if.en_1clk = 1'b0;
    repeat (4) @(negedge clk);
    u_if.debclk_10hz = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    if (do_tick) m_tick();
    m_sample(mp, up);
    check_all(do_tick ? "sample+tick" : "sample");
  endtask

  task automatic press_mode();
    sample(0, 0, 0);
    sample(1, 0, 0);
  endtask

  task automatic press_up();
    sample(0, 0, 0);
    sample(0, 1, 0);
  endtask

  task automatic goto_mode(input int target);
    for (int k = 0; k < 3 && m_mode != target; k++) press_mode();
  endtask

  task automatic set_hour(input int h);
    for (int k = 0; k < 24 && m_hour != h; k++) press_up();
  endtask

  task automatic set_min(input int mval);
    for (int k = 0; k < 60 && m_min != mval; k++) press_up();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    u_if.en_1clk     = 1'b0;
    u_if.debclk_10hz = 1'b0;
    drive_btn(0, 0);
    m_reset();
    m_days = 0;
    up_lvl = 0;

    repeat (3) @(negedge clk);
    check_all("reset");
    check("reset day_pulse", int'(u_if.day_pulse), 0);
    rst = 1'b1;

    repeat (75) tick();

    // MODE action on the same edge as a tick in RUN.
    sample(1, 0, 1);
    repeat (3) tick();

    // Back to RUN, then a bouncing MODE press between strobes steps once.
    goto_mode(0);
    sample(0, 0, 0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); u_if.btn_mode = 1'($urandom_range(0, 1));
    end
    sample(1, 0, 0);
    check("bounce mode", int'(u_if.mode), 1);
    repeat (3) sample(1, 0, 0);

    // Hold UP for ten samples in SET_HR from hour 22.
    goto_mode(1);
    set_hour(22);
    sample(0, 0, 0);
    repeat (10) sample(0, 1, 0);
    sample(0, 0, 0);

    // Day rollover from 23:59:00.
    set_hour(23);
    goto_mode(2);
    set_min(59);
    goto_mode(0);
    repeat (59) tick();
    check("pre-rollover days", day_cnt, 0);
    tick();
    check("rollover days", day_cnt, 1);

    // Random mix of ticks, samples and coincident ticks.
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 99);
      if (r < 30) begin
        tick();
      end else begin
        if ($urandom_range(0, 3) == 0) up_lvl = !up_lvl;
        sample($urandom_range(0, 9) == 0, up_lvl, $urandom_range(0, 7) == 0);
      end
    end

    // Reset in SET_MIN while UP is held; the held button must not act afterwards.
    sample(0, 0, 0);
    goto_mode(2);
    repeat (3) sample(0, 1, 0);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    m_reset();
    check_all("async reset");
    check("async reset day_pulse", int'(u_if.day_pulse), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (8) sample(0, 1, 0);
    check("held up after reset hour", int'(u_if.hour), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
